// File: rtl/rr_request_queue.sv
// rr_request_queue: per-port FIFOs feeding a 4-port round-robin arbiter.
// Request excludes the entry popped this cycle, so a grant that arrives one
// cycle after its request always finds a non-empty FIFO.
module rr_request_queue #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [3:0]      In_Valid,
    input  logic [4*DW-1:0] In_Data,
    output logic [3:0]      In_Ready,
    output logic [3:0]      Request,
    input  logic [3:0]      Grant,
    output logic            Out_Valid,
    output logic [DW-1:0]   Out_Data,
    output logic [1:0]      Out_Port,
    output logic            Grant_Err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem_q [4][DEPTH];
    logic [AW-1:0] wr_ptr_q [4];
    logic [AW-1:0] wr_ptr_d [4];
    logic [AW-1:0] rd_ptr_q [4];
    logic [AW-1:0] rd_ptr_d [4];
    logic [CW-1:0] count_q  [4];
    logic [CW-1:0] count_d  [4];

    logic [3:0] push;
    logic [3:0] pop;
    logic       grant_onehot;
    logic       pop_any;
    logic       grant_err_now;
    logic [1:0] pop_idx;

    // Decode push/pop strobes, ready/request flags and grant legality.
    always_comb begin
        grant_onehot = (Grant != 4'b0000) && ((Grant & (Grant - 4'd1)) == 4'b0000);
        pop_idx      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            In_Ready[i] = (count_q[i] < CW'(DEPTH));
            push[i]     = In_Valid[i] & In_Ready[i];
            pop[i]      = grant_onehot & Grant[i] & (count_q[i] != '0);
            // An entry being popped now must not keep the request alive.
            Request[i]  = pop[i] ? (count_q[i] > CW'(1)) : (count_q[i] != '0);
            if (pop[i]) begin
                pop_idx = 2'(i);
            end
        end
        pop_any       = |pop;
        // Multi-hot grants and grants to empty ports both leave pop at zero.
        grant_err_now = (Grant != 4'b0000) & ~pop_any;
    end

    // Next pointer and occupancy values per port.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + AW'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + AW'(pop[i]);
            unique case ({push[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + CW'(1);
                2'b01:   count_d[i] = count_q[i] - CW'(1);
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    // FIFO storage; contents need no reset since pointers and counts do.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= In_Data[i*DW +: DW];
            end
        end
    end

    // Pointer, count, output channel and sticky error registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            Out_Valid <= 1'b0;
            Out_Data  <= '0;
            Out_Port  <= 2'd0;
            Grant_Err <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            Out_Valid <= pop_any;
            if (pop_any) begin
                Out_Data <= mem_q[pop_idx][rd_ptr_q[pop_idx]];
                Out_Port <= pop_idx;
            end
            Grant_Err <= Grant_Err | grant_err_now;
        end
    end

endmodule

// File: tb/tb_rr_request_queue.sv
// tb_rr_request_queue: directed vector table plus hand-written sequences
// for pointer wrap, grant errors, reset and a round-robin arbiter loop.
module tb_rr_request_queue;

    logic        clk;
    logic        reset;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic [3:0]  request;
    logic [3:0]  grant;
    logic [3:0]  tb_gnt;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_port;
    logic        grant_err;

    int total = 0;
    int bad   = 0;

    // Bench round-robin arbiter: grant registered from the previous Request.
    logic       arb_en;
    logic [3:0] arb_gnt;
    logic [1:0] arb_last;
    logic [3:0] arb_next;
    logic [1:0] arb_next_last;
    logic [1:0] arb_ix;

    assign grant = arb_en ? arb_gnt : tb_gnt;

    rr_request_queue #(.DW(8), .DEPTH(4)) dut (
        .Clk       (clk),
        .Reset     (reset),
        .In_Valid  (in_valid),
        .In_Data   (in_data),
        .In_Ready  (in_ready),
        .Request   (request),
        .Grant     (grant),
        .Out_Valid (out_valid),
        .Out_Data  (out_data),
        .Out_Port  (out_port),
        .Grant_Err (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pick the first requester after the last granted port.
    always_comb begin
        arb_next      = 4'b0000;
        arb_next_last = arb_last;
        arb_ix        = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            arb_ix = arb_last + 2'(k);
            if (request[arb_ix]) begin
                arb_next      = 4'b0001 << arb_ix;
                arb_next_last = arb_ix;
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            arb_gnt  <= 4'b0000;
            arb_last <= 2'd3;
        end else begin
            arb_gnt  <= arb_next;
            arb_last <= arb_next_last;
        end
    end

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic [3:0]  req;
        logic [3:0]  rdy;
        logic        ov;
        logic [7:0]  od;
        logic [1:0]  op;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic [3:0] vld, input logic [31:0] data,
                                input logic [3:0] gnt, input logic [3:0] req,
                                input logic [3:0] rdy, input logic ov,
                                input logic [7:0] od, input logic [1:0] op);
        vec_t v;
        v.vld = vld; v.data = data; v.gnt = gnt; v.req = req;
        v.rdy = rdy; v.ov = ov; v.od = od; v.op = op;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs away from the active edge, then let comb settle.
    task automatic cyc(input logic rst, input logic [3:0] vld, input logic [31:0] data,
                       input logic [3:0] gnt);
        @(negedge clk);
        reset    = rst;
        in_valid = vld;
        in_data  = data;
        tb_gnt   = gnt;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] exp_d;

        reset    = 1'b1;
        in_valid = 4'b0;
        in_data  = 32'h0;
        tb_gnt   = 4'b0;
        arb_en   = 1'b0;
        repeat (2) @(posedge clk);

        // idle after reset
        for (int i = 0; i < 5; i++) vecs[i] = mk(4'b0, 32'h0, 4'b0, 4'b0000, 4'b1111, 0, 8'h00, 2'd0);
        // single word through port 2
        vecs[5]  = mk(4'b0100, 32'h00A10000, 4'b0000, 4'b0000, 4'b1111, 0, 8'h00, 2'd0);
        vecs[6]  = mk(4'b0000, 32'h0, 4'b0000, 4'b0100, 4'b1111, 0, 8'h00, 2'd0);
        vecs[7]  = mk(4'b0000, 32'h0, 4'b0100, 4'b0000, 4'b1111, 0, 8'h00, 2'd0);
        vecs[8]  = mk(4'b0000, 32'h0, 4'b0000, 4'b0000, 4'b1111, 1, 8'hA1, 2'd2);
        vecs[9]  = mk(4'b0000, 32'h0, 4'b0000, 4'b0000, 4'b1111, 0, 8'hA1, 2'd2);
        // fill port 0, overflow push dropped, drain in order
        vecs[10] = mk(4'b0001, 32'h10, 4'b0000, 4'b0000, 4'b1111, 0, 8'hA1, 2'd2);
        vecs[11] = mk(4'b0001, 32'h11, 4'b0000, 4'b0001, 4'b1111, 0, 8'hA1, 2'd2);
        vecs[12] = mk(4'b0001, 32'h12, 4'b0000, 4'b0001, 4'b1111, 0, 8'hA1, 2'd2);
        vecs[13] = mk(4'b0001, 32'h13, 4'b0000, 4'b0001, 4'b1111, 0, 8'hA1, 2'd2);
        vecs[14] = mk(4'b0001, 32'h14, 4'b0000, 4'b0001, 4'b1110, 0, 8'hA1, 2'd2);
        vecs[15] = mk(4'b0000, 32'h0, 4'b0001, 4'b0001, 4'b1110, 0, 8'hA1, 2'd2);
        vecs[16] = mk(4'b0000, 32'h0, 4'b0001, 4'b0001, 4'b1111, 1, 8'h10, 2'd0);
        vecs[17] = mk(4'b0000, 32'h0, 4'b0001, 4'b0001, 4'b1111, 1, 8'h11, 2'd0);
        vecs[18] = mk(4'b0000, 32'h0, 4'b0001, 4'b0000, 4'b1111, 1, 8'h12, 2'd0);
        vecs[19] = mk(4'b0000, 32'h0, 4'b0000, 4'b0000, 4'b1111, 1, 8'h13, 2'd0);
        vecs[20] = mk(4'b0000, 32'h0, 4'b0000, 4'b0000, 4'b1111, 0, 8'h13, 2'd0);

        for (int i = 0; i < 21; i++) begin
            cyc(1'b0, vecs[i].vld, vecs[i].data, vecs[i].gnt);
            chk("tbl_request",  i, 32'(request),   32'(vecs[i].req));
            chk("tbl_in_ready", i, 32'(in_ready),  32'(vecs[i].rdy));
            chk("tbl_out_vld",  i, 32'(out_valid), 32'(vecs[i].ov));
            chk("tbl_out_data", i, 32'(out_data),  32'(vecs[i].od));
            chk("tbl_out_port", i, 32'(out_port),  32'(vecs[i].op));
            chk("tbl_err",      i, 32'(grant_err), 32'd0);
        end

        // Port 1: fill, then push and pop together across the pointer wrap.
        cyc(1'b1, 4'b0, 32'h0, 4'b0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 4'b0010, 32'(8'h20 + k) << 8, 4'b0);
        cyc(1'b0, 4'b0, 32'h0, 4'b0);
        chk("wrap_full_rdy", 0, 32'(in_ready[1]), 32'd0);
        chk("wrap_full_req", 0, 32'(request[1]), 32'd1);
        cyc(1'b0, 4'b0, 32'h0, 4'b0010);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 4'b0010, 32'(8'h24 + k) << 8, 4'b0010);
            chk("wrap_mix_rdy",  k, 32'(in_ready[1]), 32'd1);
            chk("wrap_mix_req",  k, 32'(request[1]), 32'd1);
            chk("wrap_mix_ov",   k, 32'(out_valid), 32'd1);
            chk("wrap_mix_data", k, 32'(out_data), 32'(8'h20 + k));
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 4'b0, 32'h0, 4'b0010);
            chk("wrap_tail_data", k, 32'(out_data), 32'(8'h24 + k));
            chk("wrap_tail_port", k, 32'(out_port), 32'd1);
        end
        chk("wrap_last_req", 0, 32'(request[1]), 32'd0);
        cyc(1'b0, 4'b0, 32'h0, 4'b0);
        chk("wrap_end_data", 0, 32'(out_data), 32'h27);
        chk("wrap_end_ov", 0, 32'(out_valid), 32'd1);
        cyc(1'b0, 4'b0, 32'h0, 4'b0);
        chk("wrap_idle_ov", 0, 32'(out_valid), 32'd0);
        chk("wrap_idle_req", 0, 32'(request), 32'd0);

        // Grant errors: multi-hot, then reset mid-operation, then empty-port grant.
        cyc(1'b1, 4'b0, 32'h0, 4'b0);
        cyc(1'b0, 4'b0110, 32'h00626100, 4'b0);
        cyc(1'b0, 4'b0, 32'h0, 4'b0110);
        chk("err_multi_req", 0, 32'(request), 32'b0110);
        chk("err_multi_pre", 0, 32'(grant_err), 32'd0);
        cyc(1'b0, 4'b0, 32'h0, 4'b0);
        chk("err_multi_flag", 0, 32'(grant_err), 32'd1);
        chk("err_multi_ov", 0, 32'(out_valid), 32'd0);
        chk("err_multi_nopop", 0, 32'(request), 32'b0110);
        cyc(1'b1, 4'b0, 32'h0, 4'b0010);
        chk("err_rst_hold", 0, 32'(grant_err), 32'd1);
        cyc(1'b0, 4'b0, 32'h0, 4'b0);
        chk("rst_err_clear", 0, 32'(grant_err), 32'd0);
        chk("rst_no_pop", 0, 32'(out_valid), 32'd0);
        chk("rst_req", 0, 32'(request), 32'd0);
        chk("rst_rdy", 0, 32'(in_ready), 32'b1111);
        cyc(1'b0, 4'b0, 32'h0, 4'b1000);
        chk("err_empty_req", 0, 32'(request), 32'd0);
        cyc(1'b0, 4'b0, 32'h0, 4'b0);
        chk("err_empty_flag", 0, 32'(grant_err), 32'd1);
        chk("err_empty_ov", 0, 32'(out_valid), 32'd0);
        cyc(1'b0, 4'b0, 32'h0, 4'b0);
        chk("err_sticky", 0, 32'(grant_err), 32'd1);
        cyc(1'b1, 4'b0, 32'h0, 4'b0);
        cyc(1'b0, 4'b0, 32'h0, 4'b0);
        chk("err_cleared", 0, 32'(grant_err), 32'd0);

        // Closed loop with the arbiter: two entries per port.
        arb_en = 1'b1;
        cyc(1'b0, 4'b1111, 32'h43424140, 4'b0);
        cyc(1'b0, 4'b1111, 32'h53525150, 4'b0);
        n = 0;
        for (int c = 0; c < 30; c++) begin
            cyc(1'b0, 4'b0, 32'h0, 4'b0);
            chk("arb_err", c, 32'(grant_err), 32'd0);
            if (out_valid) begin
                exp_d = ((n < 4) ? 8'h40 : 8'h50) + 8'(n % 4);
                chk("arb_port", n, 32'(out_port), 32'(n % 4));
                chk("arb_data", n, 32'(out_data), 32'(exp_d));
                n++;
            end
        end
        chk("arb_beats", 0, 32'(n), 32'd8);
        chk("arb_drained", 0, 32'(request), 32'd0);
        arb_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_request_queue.md
Name: rr_request_queue

Overview:
- Upstream feeder for the 4-port round-robin arbiter.
- Holds one small FIFO per requester and drives the arbiter's 4-bit Request vector from FIFO occupancy.
- Consumes the arbiter's one-hot Grant by popping the granted port's head entry and presenting it on a single registered output channel tagged with the port index.
- Sized so the arbiter never sees a request that cannot be served, even though its Grant lags Request by one cycle.

Parameters:
DW, 8, data word width per port
DEPTH, 4, entries per port FIFO; power of two, >= 2

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset; clock Clk
In_Valid  input  4  per-port push strobe, bit i pushes port i
In_Data  input  4*DW  port i word at bits [i*DW +: DW]
In_Ready  output  4  per-port not-full; push accepted when In_Valid[i] & In_Ready[i]
Request  output  4  to arbiter Request; combinational
Grant  input  4  from arbiter Grant; one-hot or zero, registered in arbiter
Out_Valid  output  1  registered; popped word valid this cycle
Out_Data  output  DW  registered popped word
Out_Port  output  2  registered index of port that supplied Out_Data
Grant_Err  output  1  sticky error flag

Behaviour:
- Per-port state: wr_ptr, rd_ptr (log2(DEPTH) bits, wrap modulo DEPTH), count (log2(DEPTH)+1 bits, range 0..DEPTH).
- Reset (sync, high):
  - All pointers and counts are 0.
  - Out_Valid=0, Out_Data=0, Out_Port=0, Grant_Err=0.
  - Combinational results: Request=0000, In_Ready=1111.
  - Reset mid-operation discards all queued entries; no pop occurs in the reset cycle.
- In_Ready[i] = (count_i < DEPTH). It ignores any same-cycle pop.
- Push: In_Valid[i] & In_Ready[i] writes In_Data slice i at wr_ptr_i, then wr_ptr_i+1 and count_i+1. When In_Ready[i]=0, In_Valid[i] is ignored; data is dropped and nothing changes.
- Valid grant: Grant is exactly one-hot, bit g set, and count_g > 0.
- Pop on a valid grant:
  - Next cycle Out_Valid=1, Out_Data = entry at rd_ptr_g, Out_Port=g.
  - rd_ptr_g+1, count_g-1.
  - Latency from Grant to output is one cycle.
- Any cycle without a valid pop: Out_Valid=0, and Out_Data/Out_Port hold their previous values.
- Simultaneous push and pop on the same port: count unchanged, both pointers advance. Legal at full only if In_Ready was already 1, i.e. never at count=DEPTH.
- Request[i] = (count_i - (valid pop of i this cycle)) > 0.
  - Reason: Grant reflects Request from the previous cycle, so Request must already exclude the entry being popped now.
  - This prevents a grant to a port holding a single entry in two consecutive cycles.
  - Request depends combinationally on Grant. This forms no loop because the arbiter's Grant comes from registered state only.
  - A push this cycle does not raise Request until the next cycle.
- Grant errors:
  - Error conditions: Grant with more than one bit set, or a one-hot Grant to a port with count=0.
  - Effect: Grant_Err is set to 1 and held until Reset; no pop occurs; Out_Valid=0.
  - Grant=0000 is legal idle and causes no error.
- No backpressure on the output: the consumer must accept every Out_Valid beat.

Test Plan:
- Reset, then idle 5 cycles -> Request=0000, In_Ready=1111, Out_Valid=0, Grant_Err=0.
- Push 0xA1 to port 2 at cycle 0 -> Request=0100 at cycle 1. Drive Grant=0100 at cycle 2 -> Request=0000 the same cycle; Out_Valid=1, Out_Data=0xA1, Out_Port=2 at cycle 3.
- Push 4 words 0x10..0x13 into port 0 -> In_Ready[0]=0. Further push of 0x14 is dropped. Grant=0001 for 4 cycles -> outputs 0x10,0x11,0x12,0x13 in order. After the 4th grant, Request[0]=0 in that grant cycle.
- Port 1 full with simultaneous push and Grant=0010 at count=3 -> count stays 3; FIFO order is preserved across pointer wrap (8 pushes/pops total).
- Grant=0110, then separately Grant=1000 with port 3 empty -> Grant_Err=1 sticky, no Out_Valid. Reset -> Grant_Err=0.
- Fill ports 0..3 with 2 entries each and connect the real arbiter -> output port sequence 0,1,2,3,0,1,2,3. No Grant_Err, and no grant ever lands on an empty port.
